// File: rtl/pipe_pkg.sv
// Shared types and width helpers for the generic pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // ID/EX bundle: five 32-bit words, three register indices, 5-bit shamt, 6-bit funct.
  localparam int ID_EX_CTRL_W = 16;
  localparam int ID_EX_DATA_W = 5*32 + 3*5 + 5 + 6;

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    logic [1:0] occ;
    unique case (s)
      EMPTY:   occ = OCC_EMPTY;
      ONE:     occ = OCC_ONE;
      default: occ = OCC_FULL;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating cycle counter; clear wins over increment.
module pipe_stall_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (stall_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with a 2-entry skid buffer, registered upstream ready,
// synchronous flush with control kill mask, and a stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W         = 16,
  parameter int                DATA_W         = 128,
  parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = {CTRL_W{1'b1}},
  parameter int                CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  input  logic              i_cnt_clr
);

  pipe_state_e       state_q, state_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, load_ctrl;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept, emit;

  assign accept = i_valid & ready_q;
  assign emit   = valid_q & i_ready;

  always_comb begin
    state_d     = state_q;
    load_ctrl   = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            load_ctrl   = i_ctrl;
            main_data_d = i_data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            load_ctrl   = i_ctrl;
            main_data_d = i_data;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = i_ctrl;
            skid_data_d = i_data;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_d     = ONE;
            load_ctrl   = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
    // Kill mask is folded in at load so o_ctrl comes straight from a flop.
    main_ctrl_d = load_ctrl & ~(CTRL_KILL_MASK & {CTRL_W{~valid_d}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  pipe_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .stall_i(valid_q & ~i_ready),
    .clr_i  (i_cnt_clr),
    .cnt_o  (o_stall_cnt)
  );

  assign o_valid     = valid_q;
  assign o_ready     = ready_q;
  assign o_ctrl      = main_ctrl_q;
  assign o_data      = main_data_q;
  assign o_occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: queue-of-beats reference model, directed and random traffic.
module tb_pipe_stage_reg;
  localparam int CW = 16;
  localparam int DW = 128;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0, i_cnt_clr = 1'b0;
  logic [CW-1:0] i_ctrl = '0;
  logic [DW-1:0] i_data = '0;

  logic          a_ready, a_valid, b_ready, b_valid;
  logic [CW-1:0] a_ctrl, b_ctrl;
  logic [DW-1:0] a_data, b_data;
  logic [1:0]    a_occ, b_occ;
  logic [NW-1:0] a_cnt, b_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_KILL_MASK({CW{1'b1}}), .CNT_W(NW)) dut_a (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(a_ready),
    .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(a_valid), .i_ready(i_ready),
    .o_ctrl(a_ctrl), .o_data(a_data), .o_occupancy(a_occ), .o_stall_cnt(a_cnt),
    .i_cnt_clr(i_cnt_clr)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_KILL_MASK(16'h0003), .CNT_W(NW)) dut_b (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(b_ready),
    .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(b_valid), .i_ready(i_ready),
    .o_ctrl(b_ctrl), .o_data(b_data), .o_occupancy(b_occ), .o_stall_cnt(b_cnt),
    .i_cnt_clr(i_cnt_clr)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         sb[$];
  beat_t         pb;
  int            checks = 0;
  int            errors = 0;
  int            exp_cnt = 0;
  int            n_acc = 0;
  logic [CW-1:0] last_c = '0;
  logic [DW-1:0] last_d = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: state check at negedge, emit pop and stall model after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        last_c = sb[0].c;
        last_d = sb[0].d;
      end
      chk("occupancy", 128'(a_occ), 128'(sb.size()));
      chk("valid", 128'(a_valid), 128'(sb.size() > 0));
      chk("ready", 128'(a_ready), 128'(sb.size() < 2));
      chk("ctrl", 128'(a_ctrl), 128'((sb.size() > 0) ? last_c : '0));
      chk("data", a_data, last_d);
      chk("stall_cnt", 128'(a_cnt), 128'(exp_cnt));
      chk("b_occupancy", 128'(b_occ), 128'(sb.size()));
      chk("b_valid", 128'(b_valid), 128'(sb.size() > 0));
      chk("b_ready", 128'(b_ready), 128'(sb.size() < 2));
      chk("b_ctrl_mask3", 128'(b_ctrl), 128'((sb.size() > 0) ? last_c : (last_c & ~16'h0003)));
      chk("b_data", b_data, last_d);
      chk("b_stall_cnt", 128'(b_cnt), 128'(exp_cnt));
      #2;
      if (!reset && a_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("emit_unexpected", 128'(a_valid), 128'(0));
        end else begin
          pb = sb.pop_front();
          chk("emit_ctrl", 128'(a_ctrl), 128'(pb.c));
          chk("emit_data", a_data, pb.d);
        end
      end
      if (reset || i_cnt_clr) exp_cnt = 0;
      else if (a_valid && !i_ready && exp_cnt < 15) exp_cnt++;
    end
  end

  // Called at negedge+1; returns at the following negedge+1.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic rdy, input logic fl, input logic clr);
    i_valid = v; i_ctrl = c; i_data = d; i_ready = rdy; i_flush = fl; i_cnt_clr = clr;
    if (v && a_ready && !fl && !reset) begin
      sb.push_back({c, d});
      n_acc++;
    end
    #2;
    if (fl) sb.delete();
    @(negedge clk);
    #1;
  endtask

  logic [DW-1:0] d3, da;
  int            base, cyc;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 128'(a_valid), 128'(0));
    chk("rst_ready", 128'(a_ready), 128'(1));
    chk("rst_occ", 128'(a_occ), 128'(0));
    chk("rst_ctrl", 128'(a_ctrl), 128'(0));
    chk("rst_data", a_data, 128'(0));
    chk("rst_cnt", 128'(a_cnt), 128'(0));
    reset = 1'b0;

    // Single beat
    step(1'b1, 16'h00FF, 128'hA5, 1'b1, 1'b0, 1'b0);
    chk("beat_valid", 128'(a_valid), 128'(1));
    chk("beat_ctrl", 128'(a_ctrl), 128'(16'h00FF));
    chk("beat_data", a_data, 128'hA5);
    chk("beat_occ", 128'(a_occ), 128'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("beat_occ_after", 128'(a_occ), 128'(0));

    // Backpressure: three beats, third held upstream
    step(1'b1, 16'd1, rnd128(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'd2, rnd128(), 1'b0, 1'b0, 1'b0);
    chk("bp_ready_low", 128'(a_ready), 128'(0));
    d3 = rnd128();
    step(1'b1, 16'd3, d3, 1'b0, 1'b0, 1'b0);
    chk("bp_occ_full", 128'(a_occ), 128'(2));
    step(1'b1, 16'd3, d3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd3, d3, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_drained", 128'(a_occ), 128'(0));

    // Flush while FULL with a concurrent input beat
    da = rnd128();
    step(1'b1, 16'hFFFF, da, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h1234, rnd128(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h5555, rnd128(), 1'b0, 1'b1, 1'b0);
    chk("flush_occ", 128'(a_occ), 128'(0));
    chk("flush_valid", 128'(a_valid), 128'(0));
    chk("flush_ctrl", 128'(a_ctrl), 128'(0));
    chk("flush_ctrl_mask3", 128'(b_ctrl), 128'(16'hFFFC));
    chk("flush_data_held", a_data, da);
    chk("flush_ready", 128'(a_ready), 128'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_input_dropped", 128'(a_occ), 128'(0));

    // Stall counter saturation and clear priority
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h0042, rnd128(), 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall_sat", 128'(a_cnt), 128'(15));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("stall_clr", 128'(a_cnt), 128'(0));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle while FULL
    step(1'b1, 16'hABCD, rnd128(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h1357, rnd128(), 1'b0, 1'b0, 1'b0);
    chk("ar_full", 128'(a_occ), 128'(2));
    i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0; i_cnt_clr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 128'(a_valid), 128'(0));
    chk("ar_ready", 128'(a_ready), 128'(1));
    chk("ar_occ", 128'(a_occ), 128'(0));
    chk("ar_ctrl", 128'(a_ctrl), 128'(0));
    chk("ar_data", a_data, 128'(0));
    chk("ar_cnt", 128'(a_cnt), 128'(0));
    sb.delete();
    exp_cnt = 0;
    last_c = '0;
    last_d = '0;
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Full-throughput burst
    base = n_acc;
    repeat (50) step(1'b1, CW'($urandom), rnd128(), 1'b1, 1'b0, 1'b0);
    chk("throughput", 128'(n_acc - base), 128'(50));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Random streaming
    base = n_acc;
    cyc = 0;
    while ((n_acc - base) < 1000 && cyc < 20000) begin
      step($urandom_range(0, 99) < 70, CW'($urandom), rnd128(), $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
      cyc++;
    end
    chk("random_beats", 128'((n_acc - base) >= 1000), 128'(1));
    repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("final_drained", 128'(a_occ), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
